// File: rtl/scratchpad_mem_mp.sv
// scratchpad_mem_mp: multi-port byte-addressed scratchpad with one-entry
// response registers per port and a fixed one-cycle read latency.
// Byte-lane writes, alignment / range error detection, and round-robin
// arbitration between writes that target the same word in the same cycle.
// Optional macro SPM_RAW_FWD_EN: a read accepted alongside a write to the
// same word returns the merged (post-write) word instead of the old word.
//
// Handshake: a request transfers on a rising edge where req_valid&req_ready;
// a response transfers where resp_valid&resp_ready. req_ready may depend
// combinationally on req_valid/addr of all ports (arbitration) and on
// resp_ready of its own port; requesters must not make req_valid wait on it.
module scratchpad_mem_mp #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int NP = 2,
  parameter int MS = 4096
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NP-1:0]    req_valid,
  output logic [NP-1:0]    req_ready,
  input  logic [NP*AW-1:0] req_addr,
  input  logic [NP-1:0]    req_fcn,
  input  logic [NP*2-1:0]  req_typ,
  input  logic [NP*DW-1:0] req_data,
  output logic [NP-1:0]    resp_valid,
  input  logic [NP-1:0]    resp_ready,
  output logic [NP*DW-1:0] resp_data,
  output logic [NP-1:0]    resp_err
);

  localparam int MSB   = $clog2(MS);
  localparam int WI    = MSB - 2;
  localparam int WORDS = MS / 4;
  localparam int PW    = (NP > 1) ? $clog2(NP) : 1;

  logic [DW-1:0] mem [WORDS];

  logic [AW-1:0] addr  [NP];
  logic [1:0]    off   [NP];
  logic [1:0]    typ_w [NP];
  logic [WI-1:0] idx   [NP];
  logic [3:0]    be    [NP];
  logic [DW-1:0] wdat  [NP];
  logic [DW-1:0] wmask [NP];
  logic [NP-1:0] misal, err, wr_ok, coll, win, grant, acc;

  logic [NP-1:0]    resp_valid_q, resp_valid_d;
  logic [NP-1:0]    resp_err_q, resp_err_d;
  logic [NP*DW-1:0] resp_data_q, resp_data_d;
  logic [PW-1:0]    ptr_q, ptr_d;

  // Per-port request decode: word index, byte enables, shifted data, errors.
  always_comb begin
    addr  = '{default: '0};
    off   = '{default: '0};
    typ_w = '{default: '0};
    idx   = '{default: '0};
    be    = '{default: '0};
    wdat  = '{default: '0};
    wmask = '{default: '0};
    misal = '0;
    err   = '0;
    wr_ok = '0;
    for (int p = 0; p < NP; p++) begin
      addr[p]  = req_addr[p*AW +: AW];
      off[p]   = addr[p][1:0];
      typ_w[p] = req_typ[p*2 +: 2];
      idx[p]   = addr[p][MSB-1:2];
      case (typ_w[p])
        2'd0: be[p] = 4'b0001 << off[p];
        2'd1: begin
          be[p]    = 4'b0011 << off[p];
          misal[p] = off[p][0];
        end
        2'd2: begin
          be[p]    = 4'b1111;
          misal[p] = (off[p] != 2'd0);
        end
        default: be[p] = 4'b0000;
      endcase
      err[p]   = misal[p] | (typ_w[p] == 2'd3) | (addr[p] >= AW'(MS));
      wdat[p]  = req_data[p*DW +: DW] << {off[p], 3'b000};
      wmask[p] = {{8{be[p][3]}}, {8{be[p][2]}}, {8{be[p][1]}}, {8{be[p][0]}}};
      wr_ok[p] = req_valid[p] & req_fcn[p] & ~err[p];
    end
  end

  // Same-word write collision detection and round-robin winner selection.
  always_comb begin
    int dp;
    int dq;
    int port;
    logic found;
    coll  = '0;
    win   = '0;
    dp    = 0;
    dq    = 0;
    port  = 0;
    found = 1'b0;
    ptr_d = ptr_q;
    for (int p = 0; p < NP; p++) begin
      for (int q = 0; q < NP; q++) begin
        if (q != p && wr_ok[p] && wr_ok[q] && idx[p] == idx[q]) coll[p] = 1'b1;
      end
    end
    for (int p = 0; p < NP; p++) begin
      if (coll[p]) begin
        win[p] = 1'b1;
        dp = (p + NP - int'(ptr_q)) % NP;
        for (int q = 0; q < NP; q++) begin
          dq = (q + NP - int'(ptr_q)) % NP;
          if (q != p && coll[q] && idx[q] == idx[p] && dq < dp) win[p] = 1'b0;
        end
      end
    end
    for (int k = 0; k < NP; k++) begin
      port = (int'(ptr_q) + k) % NP;
      if (!found && win[port]) begin
        ptr_d = PW'((port + 1) % NP);
        found = 1'b1;
      end
    end
    grant     = ~coll | win;
    req_ready = (~resp_valid_q | resp_ready) & grant;
    acc       = req_valid & req_ready;
  end

  // Next state of the per-port response registers (read data captured here).
  always_comb begin
    logic [DW-1:0] rd_word;
    rd_word      = '0;
    resp_valid_d = resp_valid_q;
    resp_err_d   = resp_err_q;
    resp_data_d  = resp_data_q;
    for (int p = 0; p < NP; p++) begin
      rd_word = mem[idx[p]];
`ifdef SPM_RAW_FWD_EN
      for (int q = 0; q < NP; q++) begin
        if (acc[q] && wr_ok[q] && idx[q] == idx[p])
          rd_word = (rd_word & ~wmask[q]) | (wdat[q] & wmask[q]);
      end
`endif
      if (acc[p]) begin
        resp_valid_d[p]         = 1'b1;
        resp_err_d[p]           = err[p];
        resp_data_d[p*DW +: DW] = (!req_fcn[p] && !err[p]) ? rd_word : '0;
      end else if (resp_ready[p]) begin
        resp_valid_d[p]         = 1'b0;
        resp_err_d[p]           = 1'b0;
        resp_data_d[p*DW +: DW] = '0;
      end
    end
  end

  // Response registers and arbitration pointer; reset drops pending responses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid_q <= '0;
      resp_err_q   <= '0;
      resp_data_q  <= '0;
      ptr_q        <= '0;
    end else begin
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_data_q  <= resp_data_d;
      ptr_q        <= ptr_d;
    end
  end

  // Storage array: byte-lane writes from every accepted non-error write.
  always_ff @(posedge clk) begin
    for (int p = 0; p < NP; p++) begin
      if (acc[p] && wr_ok[p]) begin
        for (int b = 0; b < 4; b++) begin
          if (be[p][b]) mem[idx[p]][b*8 +: 8] <= wdat[p][b*8 +: 8];
        end
      end
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_data  = resp_data_q;

endmodule
